// File: rtl/alu_share_arbiter_if.sv
// Operation encoding for the shared alu, plus the requester/response bus between
// the pipeline units and alu_share_arbiter.
package alu_share_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_EQ   = 4'd10,
    ALU_NE   = 4'd11
  } alu_op_e;
endpackage

interface alu_share_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = $clog2(NUM_REQ)
);
  import alu_share_pkg::*;

  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic [NUM_REQ*32-1:0] req_oper1_i;
  logic [NUM_REQ*32-1:0] req_oper2_i;
  alu_op_e [NUM_REQ-1:0] req_op_i;
  logic [NUM_REQ-1:0]    resp_valid_o;
  logic [NUM_REQ-1:0]    resp_ready_i;
  logic [31:0]           resp_result_o;
  logic                  busy_o;
  logic [IDW-1:0]        grant_id_o;

  modport master (
    output req_valid_i, req_oper1_i, req_oper2_i, req_op_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_result_o, busy_o, grant_id_o
  );

  modport slave (
    input  req_valid_i, req_oper1_i, req_oper2_i, req_op_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_result_o, busy_o, grant_id_o
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational alu between NUM_REQ requesters;
// one operation in flight: IDLE (grant) -> EXEC (evaluate) -> RESP (hold result).
module alu
  import alu_share_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic signed [31:0] sa, sb;

  assign sa = signed'(a);
  assign sb = signed'(b);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SLT:  y = {31'd0, sa < sb};
      ALU_SLTU: y = {31'd0, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = unsigned'(sa >>> b[4:0]);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      ALU_EQ:   y = {31'd0, a == b};
      ALU_NE:   y = {31'd0, a != b};
      default:  y = '0;
    endcase
  end
endmodule

module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  alu_share_arbiter_if.slave  bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Nearest set bit after ptr wins; scanning from the farthest slot lets the
  // nearest one overwrite. MSB of the result flags that any request was found.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                           input logic [IDW-1:0]     ptr);
    logic [IDW:0] res;
    int           idx;
    res = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (vld[idx]) res = {1'b1, IDW'(idx)};
    end
    return res;
  endfunction

  logic [1:0]     state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant_id;
  logic [IDW:0]   pick;
  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic [31:0]    oper1_p0, oper2_p0;
  alu_op_e        op_p0;
  logic [31:0]    alu_y;
  logic [31:0]    result_p1;

  assign pick    = rr_pick(bus.req_valid_i, rr_ptr);
  assign gnt_any = pick[IDW];
  assign gnt_idx = pick[IDW-1:0];

  alu u_alu (
    .op (op_p0),
    .a  (oper1_p0),
    .b  (oper2_p0),
    .y  (alu_y)
  );

  // Ready is masked during reset so every output reads zero while rst_i is high.
  assign bus.req_ready_o   = (state == ST_IDLE && gnt_any && !rst_i)
                             ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign bus.resp_valid_o  = (state == ST_RESP) ? (NUM_REQ'(1) << grant_id) : '0;
  assign bus.resp_result_o = result_p1;
  assign bus.busy_o        = (state != ST_IDLE);
  assign bus.grant_id_o    = grant_id;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      rr_ptr    <= IDW'(NUM_REQ - 1);
      grant_id  <= '0;
      oper1_p0  <= '0;
      oper2_p0  <= '0;
      op_p0     <= ALU_ADD;
      result_p1 <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // p0: capture the granted requester's operands
          if (gnt_any) begin
            oper1_p0 <= bus.req_oper1_i[int'(gnt_idx)*32 +: 32];
            oper2_p0 <= bus.req_oper2_i[int'(gnt_idx)*32 +: 32];
            op_p0    <= bus.req_op_i[gnt_idx];
            grant_id <= gnt_idx;
            rr_ptr   <= gnt_idx;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // p1: register the alu result
          result_p1 <= alu_y;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.resp_ready_i[grant_id]) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with two requesters; inputs change on the
// falling edge and outputs are sampled 1ns later.
module tb_alu_share_arbiter;
  import alu_share_pkg::*;

  localparam int NUM_REQ = 2;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  alu_share_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  alu_share_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] onehot(input int r);
    return 32'(1) << r;
  endfunction

  task automatic set_req(input int r, input alu_op_e op, input logic [31:0] a,
                         input logic [31:0] b);
    bus.req_op_i[r]               = op;
    bus.req_oper1_i[r*32 +: 32]   = a;
    bus.req_oper2_i[r*32 +: 32]   = b;
  endtask

  // One uncontended operation from requester r, fully handshaked.
  task automatic single_op(input string tag, input int r, input alu_op_e op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
    @(negedge clk);
    set_req(r, op, a, b);
    bus.req_valid_i    = '0;
    bus.req_valid_i[r] = 1'b1;
    #1 chk({tag, ".ready"}, 32'(bus.req_ready_o), onehot(r));
    @(negedge clk);
    bus.req_valid_i = '0;
    #1 chk({tag, ".busy"}, 32'(bus.busy_o), 32'd1);
    @(negedge clk);
    #1;
    chk({tag, ".resp_valid"}, 32'(bus.resp_valid_o), onehot(r));
    chk({tag, ".result"}, bus.resp_result_o, exp);
    chk({tag, ".grant_id"}, 32'(bus.grant_id_o), 32'(r));
    bus.resp_ready_i[r] = 1'b1;
    @(negedge clk);
    bus.resp_ready_i = '0;
    #1 chk({tag, ".idle"}, 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.req_valid_i  = '0;
    bus.resp_ready_i = '0;
    bus.req_oper1_i  = '0;
    bus.req_oper2_i  = '0;
    for (int k = 0; k < NUM_REQ; k++) bus.req_op_i[k] = ALU_ADD;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst.ready", 32'(bus.req_ready_o), 32'd0);
    chk("rst.resp_valid", 32'(bus.resp_valid_o), 32'd0);
    chk("rst.result", bus.resp_result_o, 32'd0);
    chk("rst.busy", 32'(bus.busy_o), 32'd0);
    chk("rst.grant_id", 32'(bus.grant_id_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    single_op("add5_7", 0, ALU_ADD, 32'd5, 32'd7, 32'd12);

    // Alternation under continuous contention, starting from a fresh reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_req(0, ALU_ADD, 32'd1, 32'd1);
    set_req(1, ALU_SUB, 32'd10, 32'd3);
    bus.resp_ready_i = '1;
    bus.req_valid_i  = '1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("alt%0d.ready", i), 32'(bus.req_ready_o), onehot(i % 2));
      @(negedge clk);
      @(negedge clk);
      #1;
      chk($sformatf("alt%0d.resp_valid", i), 32'(bus.resp_valid_o), onehot(i % 2));
      chk($sformatf("alt%0d.result", i), bus.resp_result_o, (i % 2 == 1) ? 32'd7 : 32'd2);
      chk($sformatf("alt%0d.grant_id", i), 32'(bus.grant_id_o), 32'(i % 2));
      if (i == 3) bus.req_valid_i = '0;
      @(negedge clk);
      #1;
    end
    bus.resp_ready_i = '0;

    // Backpressure: r0 result held while r1 waits; r1's ready bit must not release r0
    @(negedge clk);
    set_req(0, ALU_ADD, 32'h100, 32'h23);
    bus.req_valid_i = 2'b01;
    #1 chk("bp.ready_r0", 32'(bus.req_ready_o), 32'd1);
    @(negedge clk);
    bus.req_valid_i  = 2'b10;
    bus.resp_ready_i = 2'b10;
    #1 chk("bp.exec_ready", 32'(bus.req_ready_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("bp%0d.resp_valid", i), 32'(bus.resp_valid_o), 32'd1);
      chk($sformatf("bp%0d.result", i), bus.resp_result_o, 32'h123);
      chk($sformatf("bp%0d.ready", i), 32'(bus.req_ready_o), 32'd0);
    end
    bus.resp_ready_i = 2'b01;
    @(negedge clk);
    bus.resp_ready_i = '0;
    #1 chk("bp.ready_r1", 32'(bus.req_ready_o), 32'd2);
    @(negedge clk);
    bus.req_valid_i = '0;
    @(negedge clk);
    #1;
    chk("bp.r1_valid", 32'(bus.resp_valid_o), 32'd2);
    chk("bp.r1_result", bus.resp_result_o, 32'd7);
    bus.resp_ready_i = 2'b10;
    @(negedge clk);
    bus.resp_ready_i = '0;

    // Boundary operations
    single_op("add_wrap", 0, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0);
    single_op("slt_neg", 0, ALU_SLT, 32'h8000_0000, 32'd1, 32'd1);
    single_op("sltu_big", 0, ALU_SLTU, 32'h8000_0000, 32'd1, 32'd0);
    single_op("sll_mask", 0, ALU_SLL, 32'd1, 32'h21, 32'd2);
    single_op("illegal", 0, alu_op_e'(4'hF), 32'h1234_5678, 32'h9ABC_DEF0, 32'd0);

    // Async reset during EXEC: r1 is in flight (rr_ptr=0), afterwards r0 must win
    @(negedge clk);
    set_req(0, ALU_ADD, 32'd3, 32'd4);
    set_req(1, ALU_ADD, 32'd100, 32'd1);
    bus.req_valid_i = 2'b11;
    #1 chk("ar.ready_r1", 32'(bus.req_ready_o), 32'd2);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("ar.busy", 32'(bus.busy_o), 32'd0);
    chk("ar.ready", 32'(bus.req_ready_o), 32'd0);
    chk("ar.resp_valid", 32'(bus.resp_valid_o), 32'd0);
    chk("ar.result", bus.resp_result_o, 32'd0);
    chk("ar.grant_id", 32'(bus.grant_id_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ar.ready_r0", 32'(bus.req_ready_o), 32'd1);
    @(negedge clk);
    bus.req_valid_i = 2'b10;
    @(negedge clk);
    #1;
    chk("ar.r0_valid", 32'(bus.resp_valid_o), 32'd1);
    chk("ar.r0_result", bus.resp_result_o, 32'd7);
    bus.resp_ready_i = 2'b01;
    bus.req_valid_i  = '0;
    @(negedge clk);
    bus.resp_ready_i = '0;

    // r1 alone three times, then r0 wins contention
    single_op("r1_xor", 1, ALU_XOR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
    single_op("r1_sra", 1, ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
    single_op("r1_eq", 1, ALU_EQ, 32'd5, 32'd5, 32'd1);
    @(negedge clk);
    set_req(0, ALU_AND, 32'hFF, 32'h0F);
    set_req(1, ALU_NE, 32'd5, 32'd5);
    bus.req_valid_i = 2'b11;
    #1 chk("b2b.ready_r0", 32'(bus.req_ready_o), 32'd1);
    @(negedge clk);
    bus.req_valid_i = '0;
    @(negedge clk);
    #1;
    chk("b2b.r0_valid", 32'(bus.resp_valid_o), 32'd1);
    chk("b2b.r0_result", bus.resp_result_o, 32'h0F);
    bus.resp_ready_i = 2'b01;
    @(negedge clk);
    bus.resp_ready_i = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
